// File: rtl/alu_seq_responder.sv
// Handshaked sequential ALU: logic/arithmetic ops answer in one cycle, shifts iterate
// SHIFT_STEP bits per cycle before presenting the response.
module alu_seq_responder #(
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_alu_op,
    input  logic [31:0] req_in_a,
    input  logic [31:0] req_in_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        resp_zero,
    output logic        busy
);

    // alu_op_t encoding shared with the combinational ALU
    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpAnd  = 4'd2;
    localparam logic [3:0] OpOr   = 4'd3;
    localparam logic [3:0] OpXor  = 4'd4;
    localparam logic [3:0] OpSlt  = 4'd5;
    localparam logic [3:0] OpSltu = 4'd6;
    localparam logic [3:0] OpSll  = 4'd7;
    localparam logic [3:0] OpSrl  = 4'd8;
    localparam logic [3:0] OpSra  = 4'd9;

    localparam logic [4:0] StepW = 5'(SHIFT_STEP);

    if (!(SHIFT_STEP == 1 || SHIFT_STEP == 2 || SHIFT_STEP == 4 || SHIFT_STEP == 8))
    begin : g_bad_step
        $error("alu_seq_responder: SHIFT_STEP must be 1, 2, 4 or 8");
    end

    typedef enum logic [1:0] {StIdle, StShift, StResp} state_t;

    state_t      state_q, state_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;
    logic [31:0] shreg_q, shreg_d;
    logic [4:0]  rem_q, rem_d;
    logic [3:0]  op_q, op_d;

    logic [31:0] alu_res;
    logic [4:0]  shamt;
    logic [4:0]  step;
    logic [31:0] shifted;

    assign shamt = req_in_b[4:0];
    assign step  = (rem_q < StepW) ? rem_q : StepW;

    always_comb begin
        alu_res = 32'h0;
        unique case (req_alu_op)
            OpAdd:   alu_res = req_in_a + req_in_b;
            OpSub:   alu_res = req_in_a - req_in_b;
            OpAnd:   alu_res = req_in_a & req_in_b;
            OpOr:    alu_res = req_in_a | req_in_b;
            OpXor:   alu_res = req_in_a ^ req_in_b;
            OpSlt:   alu_res = {31'h0, $signed(req_in_a) < $signed(req_in_b)};
            OpSltu:  alu_res = {31'h0, req_in_a < req_in_b};
            OpSll, OpSrl, OpSra: alu_res = req_in_a;
            default: alu_res = 32'h0;
        endcase
    end

    always_comb begin
        shifted = shreg_q;
        unique case (op_q)
            OpSll:   shifted = shreg_q << step;
            OpSrl:   shifted = shreg_q >> step;
            OpSra:   shifted = 32'($signed(shreg_q) >>> step);
            default: shifted = shreg_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        shreg_d  = shreg_q;
        rem_d    = rem_q;
        op_d     = op_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d = req_alu_op;
                    if ((req_alu_op == OpSll || req_alu_op == OpSrl || req_alu_op == OpSra)
                        && shamt != 5'd0) begin
                        shreg_d = req_in_a;
                        rem_d   = shamt;
                        state_d = StShift;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == 32'h0);
                        state_d  = StResp;
                    end
                end
            end
            StShift: begin
                shreg_d = shifted;
                rem_d   = rem_q - step;
                if (rem_q == step) begin
                    result_d = shifted;
                    zero_d   = (shifted == 32'h0);
                    state_d  = StResp;
                end
            end
            StResp: begin
                if (resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            result_q <= 32'h0;
            zero_q   <= 1'b0;
            shreg_q  <= 32'h0;
            rem_q    <= 5'd0;
            op_q     <= 4'd0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            shreg_q  <= shreg_d;
            rem_q    <= rem_d;
            op_q     <= op_d;
        end
    end

    assign req_ready   = (state_q == StIdle);
    assign resp_valid  = (state_q == StResp);
    assign busy        = (state_q != StIdle);
    assign resp_result = result_q;
    assign resp_zero   = zero_q;

endmodule
